// File: rtl/id_ex_operand_stage_if.sv
// ID/EX stage bus: ID-side capture inputs, bypass sources and EX-side outputs.
// The master modport drives the ID and bypass side; the slave modport is the stage itself.
interface id_ex_operand_stage_if #(
    parameter int XLEN   = 2,
    parameter int CTRL_W = 16
);
    localparam int W = 1 << (XLEN + 4);

    logic              i_clk_enable;
    logic              i_flush;
    logic              i_id_valid;
    logic [4:0]        i_rs1_addr;
    logic [4:0]        i_rs2_addr;
    logic [4:0]        i_rd_addr;
    logic              i_rs1_used;
    logic              i_rs2_used;
    logic [W-1:0]      i_rs1_data;
    logic [W-1:0]      i_rs2_data;
    logic [W-1:0]      i_imm;
    logic [CTRL_W-1:0] i_ctrl;
    logic              i_is_load;
    logic [4:0]        i_exmem_rd;
    logic              i_exmem_reg_write;
    logic [W-1:0]      i_exmem_data;
    logic [4:0]        i_memwb_rd;
    logic              i_memwb_reg_write;
    logic [W-1:0]      i_memwb_data;

    logic              o_ex_valid;
    logic [W-1:0]      o_op_a;
    logic [W-1:0]      o_op_b;
    logic [W-1:0]      o_rs1_data_raw;
    logic [W-1:0]      o_rs2_data_raw;
    logic [W-1:0]      o_imm;
    logic [CTRL_W-1:0] o_ctrl;
    logic [4:0]        o_rd_addr;
    logic              o_is_load;
    logic [1:0]        o_fwd_a_sel;
    logic [1:0]        o_fwd_b_sel;
    logic              o_load_use_stall;

    modport master (
        output i_clk_enable, i_flush, i_id_valid, i_rs1_addr, i_rs2_addr, i_rd_addr,
               i_rs1_used, i_rs2_used, i_rs1_data, i_rs2_data, i_imm, i_ctrl, i_is_load,
               i_exmem_rd, i_exmem_reg_write, i_exmem_data,
               i_memwb_rd, i_memwb_reg_write, i_memwb_data,
        input  o_ex_valid, o_op_a, o_op_b, o_rs1_data_raw, o_rs2_data_raw, o_imm, o_ctrl,
               o_rd_addr, o_is_load, o_fwd_a_sel, o_fwd_b_sel, o_load_use_stall
    );

    modport slave (
        input  i_clk_enable, i_flush, i_id_valid, i_rs1_addr, i_rs2_addr, i_rd_addr,
               i_rs1_used, i_rs2_used, i_rs1_data, i_rs2_data, i_imm, i_ctrl, i_is_load,
               i_exmem_rd, i_exmem_reg_write, i_exmem_data,
               i_memwb_rd, i_memwb_reg_write, i_memwb_data,
        output o_ex_valid, o_op_a, o_op_b, o_rs1_data_raw, o_rs2_data_raw, o_imm, o_ctrl,
               o_rd_addr, o_is_load, o_fwd_a_sel, o_fwd_b_sel, o_load_use_stall
    );
endinterface

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with EX-side operand bypass and load-use hazard detection.
// Define ID_EX_PERF_EN to add the o_fwd_count / o_bubble_count performance counters.
module id_ex_operand_stage #(
    parameter int XLEN   = 2,
    parameter int CTRL_W = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    id_ex_operand_stage_if.slave bus
`ifdef ID_EX_PERF_EN
    ,
    output logic [31:0] o_fwd_count,
    output logic [31:0] o_bubble_count
`endif
);
    localparam int W = 1 << (XLEN + 4);

    logic              ex_valid_reg, ex_valid_next;
    logic [4:0]        rd_reg, rd_next;
    logic              is_load_reg, is_load_next;
    logic [CTRL_W-1:0] ctrl_reg, ctrl_next;
    logic [W-1:0]      imm_reg, imm_next;
    logic [4:0]        rs_addr_reg [2];
    logic [4:0]        rs_addr_next [2];
    logic [W-1:0]      rs_data_reg [2];
    logic [W-1:0]      rs_data_next [2];

    logic [4:0]        id_rs_addr [2];
    logic [W-1:0]      id_rs_data [2];
    logic [1:0]        id_rs_used;
    logic [1:0]        exmem_hit;
    logic [1:0]        memwb_hit;
    logic [1:0]        fwd_sel [2];
    logic [W-1:0]      op [2];
    logic [1:0]        id_rs_match;
    logic              load_use_stall;

    assign id_rs_addr[0] = bus.i_rs1_addr;
    assign id_rs_addr[1] = bus.i_rs2_addr;
    assign id_rs_data[0] = bus.i_rs1_data;
    assign id_rs_data[1] = bus.i_rs2_data;
    assign id_rs_used    = {bus.i_rs2_used, bus.i_rs1_used};

    // Per-operand bypass select and hazard compare; a zero register address can never hit.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_operand
            assign exmem_hit[gi] = bus.i_exmem_reg_write && (bus.i_exmem_rd != 5'd0)
                                   && (bus.i_exmem_rd == rs_addr_reg[gi]);
            assign memwb_hit[gi] = bus.i_memwb_reg_write && (bus.i_memwb_rd != 5'd0)
                                   && (bus.i_memwb_rd == rs_addr_reg[gi]);
            assign fwd_sel[gi]   = exmem_hit[gi] ? 2'b10 : (memwb_hit[gi] ? 2'b01 : 2'b00);
            assign op[gi]        = exmem_hit[gi] ? bus.i_exmem_data :
                                   (memwb_hit[gi] ? bus.i_memwb_data : rs_data_reg[gi]);
            assign id_rs_match[gi] = id_rs_used[gi] && (id_rs_addr[gi] == rd_reg);
        end
    endgenerate

    assign load_use_stall = ex_valid_reg && is_load_reg && (rd_reg != 5'd0)
                            && (|id_rs_match) && !bus.i_flush;

    always_comb begin
        ex_valid_next   = ex_valid_reg;
        rd_next         = rd_reg;
        is_load_next    = is_load_reg;
        ctrl_next       = ctrl_reg;
        imm_next        = imm_reg;
        rs_addr_next[0] = rs_addr_reg[0];
        rs_addr_next[1] = rs_addr_reg[1];
        rs_data_next[0] = rs_data_reg[0];
        rs_data_next[1] = rs_data_reg[1];
        if (!bus.i_clk_enable) begin
            ex_valid_next = ex_valid_reg;
        end else if (bus.i_flush || load_use_stall) begin
            // Bubble: everything zeroed so a stale load cannot re-trigger the stall.
            ex_valid_next   = 1'b0;
            rd_next         = '0;
            is_load_next    = 1'b0;
            ctrl_next       = '0;
            imm_next        = '0;
            rs_addr_next[0] = '0;
            rs_addr_next[1] = '0;
            rs_data_next[0] = '0;
            rs_data_next[1] = '0;
        end else begin
            ex_valid_next   = bus.i_id_valid;
            rd_next         = bus.i_rd_addr;
            is_load_next    = bus.i_is_load;
            ctrl_next       = bus.i_ctrl;
            imm_next        = bus.i_imm;
            rs_addr_next[0] = id_rs_used[0] ? id_rs_addr[0] : 5'd0;
            rs_addr_next[1] = id_rs_used[1] ? id_rs_addr[1] : 5'd0;
            rs_data_next[0] = id_rs_data[0];
            rs_data_next[1] = id_rs_data[1];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ex_valid_reg   <= 1'b0;
            rd_reg         <= '0;
            is_load_reg    <= 1'b0;
            ctrl_reg       <= '0;
            imm_reg        <= '0;
            rs_addr_reg[0] <= '0;
            rs_addr_reg[1] <= '0;
            rs_data_reg[0] <= '0;
            rs_data_reg[1] <= '0;
        end else begin
            ex_valid_reg   <= ex_valid_next;
            rd_reg         <= rd_next;
            is_load_reg    <= is_load_next;
            ctrl_reg       <= ctrl_next;
            imm_reg        <= imm_next;
            rs_addr_reg[0] <= rs_addr_next[0];
            rs_addr_reg[1] <= rs_addr_next[1];
            rs_data_reg[0] <= rs_data_next[0];
            rs_data_reg[1] <= rs_data_next[1];
        end
    end

    assign bus.o_ex_valid       = ex_valid_reg;
    assign bus.o_op_a           = op[0];
    assign bus.o_op_b           = op[1];
    assign bus.o_rs1_data_raw   = rs_data_reg[0];
    assign bus.o_rs2_data_raw   = rs_data_reg[1];
    assign bus.o_imm            = imm_reg;
    assign bus.o_ctrl           = ctrl_reg;
    assign bus.o_rd_addr        = rd_reg;
    assign bus.o_is_load        = is_load_reg;
    assign bus.o_fwd_a_sel      = fwd_sel[0];
    assign bus.o_fwd_b_sel      = fwd_sel[1];
    assign bus.o_load_use_stall = load_use_stall;

`ifdef ID_EX_PERF_EN
    logic [31:0] fwd_count_reg;
    logic [31:0] bubble_count_reg;

    // Counts advance only on enabled edges; each EX instruction is seen on exactly one such edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            fwd_count_reg    <= '0;
            bubble_count_reg <= '0;
        end else if (bus.i_clk_enable) begin
            if (ex_valid_reg && ((fwd_sel[0] != 2'b00) || (fwd_sel[1] != 2'b00)))
                fwd_count_reg <= fwd_count_reg + 32'd1;
            if (load_use_stall)
                bubble_count_reg <= bubble_count_reg + 32'd1;
        end
    end

    assign o_fwd_count    = fwd_count_reg;
    assign o_bubble_count = bubble_count_reg;
`endif
endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed testbench for id_ex_operand_stage: capture, bypass priority, x0, load-use, flush, freeze, reset.
module tb_id_ex_operand_stage;
    localparam int XLEN   = 2;
    localparam int CTRL_W = 16;
    localparam int W      = 1 << (XLEN + 4);

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    id_ex_operand_stage_if #(.XLEN(XLEN), .CTRL_W(CTRL_W)) dut_if ();

`ifdef ID_EX_PERF_EN
    logic [31:0] fwd_count;
    logic [31:0] bubble_count;
`endif

    id_ex_operand_stage #(.XLEN(XLEN), .CTRL_W(CTRL_W)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (dut_if.slave)
`ifdef ID_EX_PERF_EN
        ,
        .o_fwd_count    (fwd_count),
        .o_bubble_count (bubble_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        dut_if.i_clk_enable      = 1'b1;
        dut_if.i_flush           = 1'b0;
        dut_if.i_id_valid        = 1'b0;
        dut_if.i_rs1_addr        = '0;
        dut_if.i_rs2_addr        = '0;
        dut_if.i_rd_addr         = '0;
        dut_if.i_rs1_used        = 1'b0;
        dut_if.i_rs2_used        = 1'b0;
        dut_if.i_rs1_data        = '0;
        dut_if.i_rs2_data        = '0;
        dut_if.i_imm             = '0;
        dut_if.i_ctrl            = '0;
        dut_if.i_is_load         = 1'b0;
        dut_if.i_exmem_rd        = '0;
        dut_if.i_exmem_reg_write = 1'b0;
        dut_if.i_exmem_data      = '0;
        dut_if.i_memwb_rd        = '0;
        dut_if.i_memwb_reg_write = 1'b0;
        dut_if.i_memwb_data      = '0;
    endtask

    task automatic clear_bypass();
        dut_if.i_exmem_rd        = '0;
        dut_if.i_exmem_reg_write = 1'b0;
        dut_if.i_exmem_data      = '0;
        dut_if.i_memwb_rd        = '0;
        dut_if.i_memwb_reg_write = 1'b0;
        dut_if.i_memwb_data      = '0;
    endtask

    task automatic drive_load(input logic [4:0] rd);
        dut_if.i_id_valid = 1'b1;
        dut_if.i_is_load  = 1'b1;
        dut_if.i_rd_addr  = rd;
        dut_if.i_rs1_used = 1'b0;
        dut_if.i_rs2_used = 1'b0;
        dut_if.i_imm      = '0;
        dut_if.i_ctrl     = 16'h0001;
    endtask

    task automatic test_reset();
        set_idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_cmp++; if (dut_if.o_ex_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %0h want 0", dut_if.o_ex_valid); end
        n_cmp++; if (dut_if.o_rd_addr !== 5'd0) begin n_bad++; $display("FAIL reset_rd: got %0h want 0", dut_if.o_rd_addr); end
        n_cmp++; if (dut_if.o_is_load !== 1'b0) begin n_bad++; $display("FAIL reset_is_load: got %0h want 0", dut_if.o_is_load); end
        n_cmp++; if (dut_if.o_ctrl !== 16'h0) begin n_bad++; $display("FAIL reset_ctrl: got %0h want 0", dut_if.o_ctrl); end
        n_cmp++; if (dut_if.o_imm !== 64'h0) begin n_bad++; $display("FAIL reset_imm: got %0h want 0", dut_if.o_imm); end
        n_cmp++; if (dut_if.o_op_a !== 64'h0) begin n_bad++; $display("FAIL reset_op_a: got %0h want 0", dut_if.o_op_a); end
        n_cmp++; if (dut_if.o_fwd_a_sel !== 2'b00) begin n_bad++; $display("FAIL reset_sel_a: got %0b want 00", dut_if.o_fwd_a_sel); end
        n_cmp++; if (dut_if.o_load_use_stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %0h want 0", dut_if.o_load_use_stall); end
    endtask

    task automatic test_capture();
        dut_if.i_id_valid = 1'b1;
        dut_if.i_rs1_addr = 5'd3;  dut_if.i_rs1_used = 1'b1; dut_if.i_rs1_data = 64'h11;
        dut_if.i_rs2_addr = 5'd4;  dut_if.i_rs2_used = 1'b1; dut_if.i_rs2_data = 64'h22;
        dut_if.i_rd_addr  = 5'd7;  dut_if.i_imm = 64'h20;    dut_if.i_ctrl = 16'h1234;
        tick();
        n_cmp++; if (dut_if.o_ex_valid !== 1'b1) begin n_bad++; $display("FAIL cap_valid: got %0h want 1", dut_if.o_ex_valid); end
        n_cmp++; if (dut_if.o_op_a !== 64'h11) begin n_bad++; $display("FAIL cap_op_a: got %0h want 11", dut_if.o_op_a); end
        n_cmp++; if (dut_if.o_op_b !== 64'h22) begin n_bad++; $display("FAIL cap_op_b: got %0h want 22", dut_if.o_op_b); end
        n_cmp++; if (dut_if.o_imm !== 64'h20) begin n_bad++; $display("FAIL cap_imm: got %0h want 20", dut_if.o_imm); end
        n_cmp++; if (dut_if.o_ctrl !== 16'h1234) begin n_bad++; $display("FAIL cap_ctrl: got %0h want 1234", dut_if.o_ctrl); end
        n_cmp++; if (dut_if.o_rd_addr !== 5'd7) begin n_bad++; $display("FAIL cap_rd: got %0h want 7", dut_if.o_rd_addr); end
        n_cmp++; if (dut_if.o_fwd_a_sel !== 2'b00) begin n_bad++; $display("FAIL cap_sel_a: got %0b want 00", dut_if.o_fwd_a_sel); end
        $display("capture: op_a=%0h op_b=%0h imm=%0h", dut_if.o_op_a, dut_if.o_op_b, dut_if.o_imm);
    endtask

    task automatic test_forward_priority();
        dut_if.i_exmem_rd = 5'd3; dut_if.i_exmem_reg_write = 1'b1; dut_if.i_exmem_data = 64'hAA;
        dut_if.i_memwb_rd = 5'd3; dut_if.i_memwb_reg_write = 1'b1; dut_if.i_memwb_data = 64'hBB;
        #1;
        n_cmp++; if (dut_if.o_op_a !== 64'hAA) begin n_bad++; $display("FAIL fwd_exmem_op_a: got %0h want aa", dut_if.o_op_a); end
        n_cmp++; if (dut_if.o_fwd_a_sel !== 2'b10) begin n_bad++; $display("FAIL fwd_exmem_sel: got %0b want 10", dut_if.o_fwd_a_sel); end
        n_cmp++; if (dut_if.o_op_b !== 64'h22) begin n_bad++; $display("FAIL fwd_b_untouched: got %0h want 22", dut_if.o_op_b); end
        n_cmp++; if (dut_if.o_rs1_data_raw !== 64'h11) begin n_bad++; $display("FAIL fwd_raw_a: got %0h want 11", dut_if.o_rs1_data_raw); end
        dut_if.i_exmem_reg_write = 1'b0;
        #1;
        n_cmp++; if (dut_if.o_op_a !== 64'hBB) begin n_bad++; $display("FAIL fwd_memwb_op_a: got %0h want bb", dut_if.o_op_a); end
        n_cmp++; if (dut_if.o_fwd_a_sel !== 2'b01) begin n_bad++; $display("FAIL fwd_memwb_sel: got %0b want 01", dut_if.o_fwd_a_sel); end
        dut_if.i_memwb_rd = 5'd4;
        #1;
        n_cmp++; if (dut_if.o_op_b !== 64'hBB) begin n_bad++; $display("FAIL fwd_memwb_op_b: got %0h want bb", dut_if.o_op_b); end
        n_cmp++; if (dut_if.o_fwd_b_sel !== 2'b01) begin n_bad++; $display("FAIL fwd_memwb_sel_b: got %0b want 01", dut_if.o_fwd_b_sel); end
        $display("forward: op_a=%0h sel_a=%0b op_b=%0h sel_b=%0b", dut_if.o_op_a, dut_if.o_fwd_a_sel, dut_if.o_op_b, dut_if.o_fwd_b_sel);
        clear_bypass();
        set_idle();
    endtask

    task automatic test_x0_and_unused();
        dut_if.i_id_valid = 1'b1;
        dut_if.i_rs1_addr = 5'd0; dut_if.i_rs1_used = 1'b1; dut_if.i_rs1_data = '0;
        dut_if.i_rs2_addr = 5'd0; dut_if.i_rs2_used = 1'b1; dut_if.i_rs2_data = '0;
        tick();
        dut_if.i_exmem_rd = 5'd0; dut_if.i_exmem_reg_write = 1'b1; dut_if.i_exmem_data = 64'hFF;
        dut_if.i_memwb_rd = 5'd0; dut_if.i_memwb_reg_write = 1'b1; dut_if.i_memwb_data = 64'hFF;
        #1;
        n_cmp++; if (dut_if.o_op_b !== 64'h0) begin n_bad++; $display("FAIL x0_op_b: got %0h want 0", dut_if.o_op_b); end
        n_cmp++; if (dut_if.o_fwd_b_sel !== 2'b00) begin n_bad++; $display("FAIL x0_sel_b: got %0b want 00", dut_if.o_fwd_b_sel); end
        n_cmp++; if (dut_if.o_op_a !== 64'h0) begin n_bad++; $display("FAIL x0_op_a: got %0h want 0", dut_if.o_op_a); end
        clear_bypass();
        dut_if.i_rs2_addr = 5'd4; dut_if.i_rs2_used = 1'b0; dut_if.i_rs2_data = 64'h66;
        tick();
        dut_if.i_exmem_rd = 5'd4; dut_if.i_exmem_reg_write = 1'b1; dut_if.i_exmem_data = 64'hEE;
        #1;
        n_cmp++; if (dut_if.o_fwd_b_sel !== 2'b00) begin n_bad++; $display("FAIL unused_sel_b: got %0b want 00", dut_if.o_fwd_b_sel); end
        n_cmp++; if (dut_if.o_op_b !== 64'h66) begin n_bad++; $display("FAIL unused_op_b: got %0h want 66", dut_if.o_op_b); end
        $display("x0/unused: op_b=%0h sel_b=%0b", dut_if.o_op_b, dut_if.o_fwd_b_sel);
        clear_bypass();
        set_idle();
    endtask

    task automatic test_flush_freeze();
        drive_load(5'd5);
        tick();
        dut_if.i_is_load  = 1'b0;
        dut_if.i_rd_addr  = 5'd8;
        dut_if.i_rs1_addr = 5'd5; dut_if.i_rs1_used = 1'b1;
        #1;
        n_cmp++; if (dut_if.o_load_use_stall !== 1'b1) begin n_bad++; $display("FAIL pre_flush_stall: got %0h want 1", dut_if.o_load_use_stall); end
        dut_if.i_flush = 1'b1;
        #1;
        n_cmp++; if (dut_if.o_load_use_stall !== 1'b0) begin n_bad++; $display("FAIL flush_stall: got %0h want 0", dut_if.o_load_use_stall); end
        tick();
        dut_if.i_flush = 1'b0;
        n_cmp++; if (dut_if.o_ex_valid !== 1'b0) begin n_bad++; $display("FAIL flush_valid: got %0h want 0", dut_if.o_ex_valid); end
        n_cmp++; if (dut_if.o_is_load !== 1'b0) begin n_bad++; $display("FAIL flush_is_load: got %0h want 0", dut_if.o_is_load); end
        n_cmp++; if (dut_if.o_rd_addr !== 5'd0) begin n_bad++; $display("FAIL flush_rd: got %0h want 0", dut_if.o_rd_addr); end
        n_cmp++; if (dut_if.o_ctrl !== 16'h0) begin n_bad++; $display("FAIL flush_ctrl: got %0h want 0", dut_if.o_ctrl); end
        $display("flush: valid=%0h stall=%0h", dut_if.o_ex_valid, dut_if.o_load_use_stall);
        dut_if.i_rd_addr  = 5'd9; dut_if.i_imm = 64'h99; dut_if.i_ctrl = 16'h0F0F;
        dut_if.i_rs1_addr = 5'd3; dut_if.i_rs1_data = 64'h33;
        tick();
        dut_if.i_clk_enable = 1'b0;
        dut_if.i_rd_addr  = 5'd10; dut_if.i_imm = 64'hAB; dut_if.i_ctrl = 16'h5A5A;
        dut_if.i_rs1_data = 64'h44;
        dut_if.i_exmem_rd = 5'd3; dut_if.i_exmem_reg_write = 1'b1; dut_if.i_exmem_data = 64'hCC;
        repeat (3) tick();
        n_cmp++; if (dut_if.o_rd_addr !== 5'd9) begin n_bad++; $display("FAIL freeze_rd: got %0h want 9", dut_if.o_rd_addr); end
        n_cmp++; if (dut_if.o_imm !== 64'h99) begin n_bad++; $display("FAIL freeze_imm: got %0h want 99", dut_if.o_imm); end
        n_cmp++; if (dut_if.o_ctrl !== 16'h0F0F) begin n_bad++; $display("FAIL freeze_ctrl: got %0h want f0f", dut_if.o_ctrl); end
        n_cmp++; if (dut_if.o_rs1_data_raw !== 64'h33) begin n_bad++; $display("FAIL freeze_raw_a: got %0h want 33", dut_if.o_rs1_data_raw); end
        n_cmp++; if (dut_if.o_ex_valid !== 1'b1) begin n_bad++; $display("FAIL freeze_valid: got %0h want 1", dut_if.o_ex_valid); end
        n_cmp++; if (dut_if.o_op_a !== 64'hCC) begin n_bad++; $display("FAIL freeze_bypass: got %0h want cc", dut_if.o_op_a); end
        $display("freeze: rd=%0h imm=%0h op_a=%0h", dut_if.o_rd_addr, dut_if.o_imm, dut_if.o_op_a);
        clear_bypass();
        set_idle();
    endtask

    task automatic test_reset_mid_stall();
        drive_load(5'd5);
        tick();
        dut_if.i_is_load  = 1'b0;
        dut_if.i_rd_addr  = 5'd8;
        dut_if.i_rs1_addr = 5'd5; dut_if.i_rs1_used = 1'b1; dut_if.i_rs1_data = 64'h51;
        dut_if.i_imm      = 64'h7;
        #1;
        n_cmp++; if (dut_if.o_load_use_stall !== 1'b1) begin n_bad++; $display("FAIL rst_pre_stall: got %0h want 1", dut_if.o_load_use_stall); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++; if (dut_if.o_load_use_stall !== 1'b0) begin n_bad++; $display("FAIL rst_stall: got %0h want 0", dut_if.o_load_use_stall); end
        n_cmp++; if (dut_if.o_ex_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %0h want 0", dut_if.o_ex_valid); end
        n_cmp++; if (dut_if.o_rd_addr !== 5'd0) begin n_bad++; $display("FAIL rst_rd: got %0h want 0", dut_if.o_rd_addr); end
        n_cmp++; if (dut_if.o_ctrl !== 16'h0) begin n_bad++; $display("FAIL rst_ctrl: got %0h want 0", dut_if.o_ctrl); end
        n_cmp++; if (dut_if.o_op_a !== 64'h0) begin n_bad++; $display("FAIL rst_op_a: got %0h want 0", dut_if.o_op_a); end
        n_cmp++; if (dut_if.o_is_load !== 1'b0) begin n_bad++; $display("FAIL rst_is_load: got %0h want 0", dut_if.o_is_load); end
`ifdef ID_EX_PERF_EN
        n_cmp++; if (fwd_count !== 32'd0) begin n_bad++; $display("FAIL rst_fwd_count: got %0d want 0", fwd_count); end
        n_cmp++; if (bubble_count !== 32'd0) begin n_bad++; $display("FAIL rst_bubble_count: got %0d want 0", bubble_count); end
`endif
        $display("reset mid-stall: valid=%0h stall=%0h", dut_if.o_ex_valid, dut_if.o_load_use_stall);
        set_idle();
    endtask

    task automatic test_load_use();
        drive_load(5'd5);
        tick();
        dut_if.i_is_load  = 1'b0;
        dut_if.i_rd_addr  = 5'd8;
        dut_if.i_ctrl     = 16'h0002;
        dut_if.i_rs1_addr = 5'd6; dut_if.i_rs1_used = 1'b1; dut_if.i_rs1_data = 64'h61;
        dut_if.i_rs2_addr = 5'd5; dut_if.i_rs2_used = 1'b1; dut_if.i_rs2_data = 64'h62;
        #1;
        n_cmp++; if (dut_if.o_load_use_stall !== 1'b1) begin n_bad++; $display("FAIL lu_stall: got %0h want 1", dut_if.o_load_use_stall); end
        tick();
        n_cmp++; if (dut_if.o_ex_valid !== 1'b0) begin n_bad++; $display("FAIL lu_bubble_valid: got %0h want 0", dut_if.o_ex_valid); end
        n_cmp++; if (dut_if.o_load_use_stall !== 1'b0) begin n_bad++; $display("FAIL lu_stall_drop: got %0h want 0", dut_if.o_load_use_stall); end
        tick();
        n_cmp++; if (dut_if.o_ex_valid !== 1'b1) begin n_bad++; $display("FAIL lu_recap_valid: got %0h want 1", dut_if.o_ex_valid); end
        n_cmp++; if (dut_if.o_rd_addr !== 5'd8) begin n_bad++; $display("FAIL lu_recap_rd: got %0h want 8", dut_if.o_rd_addr); end
        dut_if.i_exmem_rd = 5'd5; dut_if.i_exmem_reg_write = 1'b1; dut_if.i_exmem_data = 64'h77;
        #1;
        n_cmp++; if (dut_if.o_op_b !== 64'h77) begin n_bad++; $display("FAIL lu_fwd_op_b: got %0h want 77", dut_if.o_op_b); end
        n_cmp++; if (dut_if.o_fwd_b_sel !== 2'b10) begin n_bad++; $display("FAIL lu_fwd_sel_b: got %0b want 10", dut_if.o_fwd_b_sel); end
        $display("load-use: bubble inserted, recaptured rd=%0h op_b=%0h", dut_if.o_rd_addr, dut_if.o_op_b);
        drive_load(5'd5);
        tick();
        clear_bypass();
        dut_if.i_is_load  = 1'b0;
        dut_if.i_rd_addr  = 5'd8;
        dut_if.i_rs1_addr = 5'd6; dut_if.i_rs1_used = 1'b1;
        dut_if.i_rs2_addr = 5'd5; dut_if.i_rs2_used = 1'b0;
        #1;
        n_cmp++; if (dut_if.o_load_use_stall !== 1'b0) begin n_bad++; $display("FAIL lu_unused_stall: got %0h want 0", dut_if.o_load_use_stall); end
        tick();
        n_cmp++; if (dut_if.o_ex_valid !== 1'b1) begin n_bad++; $display("FAIL lu_unused_valid: got %0h want 1", dut_if.o_ex_valid); end
        n_cmp++; if (dut_if.o_rd_addr !== 5'd8) begin n_bad++; $display("FAIL lu_unused_rd: got %0h want 8", dut_if.o_rd_addr); end
`ifdef ID_EX_PERF_EN
        n_cmp++; if (fwd_count !== 32'd1) begin n_bad++; $display("FAIL perf_fwd_count: got %0d want 1", fwd_count); end
        n_cmp++; if (bubble_count !== 32'd1) begin n_bad++; $display("FAIL perf_bubble_count: got %0d want 1", bubble_count); end
`endif
        $display("load-use unused rs2: no stall, rd=%0h", dut_if.o_rd_addr);
        set_idle();
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst   = 1'b1;
        set_idle();
        test_reset();
        test_capture();
        test_forward_priority();
        test_x0_and_unused();
        test_flush_freeze();
        test_reset_mid_stall();
        test_load_use();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
